// File: rtl/plic_prio.sv
// plic_prio: priority interrupt controller with per-source claim/complete gateways.
// Define PLIC_EDGE_EN to add per-source edge-triggered mode (register 0x001080).
module plic_prio #(
  parameter int SOURCES   = 8,
  parameter int PRIO_BITS = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [SOURCES-1:0] i_interrupt,
  input  logic               i_interrupt_enable,
  output logic               o_interrupt,
  input  logic               i_request,
  input  logic               i_rw,
  input  logic [23:0]        i_address,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ready
);
  logic [PRIO_BITS-1:0] prio [1:SOURCES];
  logic [PRIO_BITS-1:0] thr, best;
  logic [SOURCES:0]     pend, infl, en, elig, trig, repend;
  logic [4:0]           win;
  logic [31:0]          rd;
  logic                 wr, rd_claim, wr_cmp;
  logic                 unused;
  assign unused   = ^i_wdata;
  assign wr       = i_request && i_rw;
  assign rd_claim = i_request && !i_rw && i_address == 24'h200004;
  assign wr_cmp   = wr && i_address == 24'h200004;
`ifdef PLIC_EDGE_EN
  logic [SOURCES:0]   edge_m, held;
  logic [SOURCES-1:0] irq_q, irq_qq;
  // Edge sources see the input through one register stage, then detect the rise.
  assign trig   = {(SOURCES+1){i_interrupt_enable}} &
                  ((edge_m & {irq_q & ~irq_qq, 1'b0}) | (~edge_m & {i_interrupt, 1'b0}));
  assign repend = edge_m & (held | trig);
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      edge_m <= '0;
      held   <= '0;
      irq_q  <= '0;
      irq_qq <= '0;
    end else begin
      irq_q  <= i_interrupt;
      irq_qq <= irq_q;
      if (wr && i_address == 24'h001080) edge_m <= {i_wdata[SOURCES:1], 1'b0};
      for (int i = 1; i <= SOURCES; i++)
        if (wr_cmp && i_wdata[4:0] == 5'(i) && infl[i]) held[i] <= 1'b0;
        else if (infl[i] && trig[i]) held[i] <= 1'b1;
    end
`else
  assign trig   = {(SOURCES+1){i_interrupt_enable}} & {i_interrupt, 1'b0};
  assign repend = '0;
`endif
  always_comb begin
    elig = '0;
    best = '0;
    win  = '0;
    for (int i = 1; i <= SOURCES; i++) elig[i] = pend[i] && en[i] && prio[i] > thr;
    // Descending scan with >= lets the lowest id win a priority tie.
    for (int i = SOURCES; i >= 1; i--)
      if (elig[i] && prio[i] >= best) begin
        best = prio[i];
        win  = 5'(i);
      end
  end
  always_comb begin
    rd = '0;
    for (int i = 1; i <= SOURCES; i++) if (i_address == 24'(4 * i)) rd = 32'(prio[i]);
    if (i_address == 24'h001000) rd = 32'(pend);
    if (i_address == 24'h002000) rd = 32'(en);
`ifdef PLIC_EDGE_EN
    if (i_address == 24'h001080) rd = 32'(edge_m);
`endif
    if (i_address == 24'h200000) rd = 32'(thr);
    if (i_address == 24'h200004) rd = 32'(win);
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      for (int i = 1; i <= SOURCES; i++) prio[i] <= '0;
      en          <= '0;
      thr         <= '0;
      o_ready     <= 1'b0;
      o_rdata     <= '0;
      o_interrupt <= 1'b0;
    end else begin
      for (int i = 1; i <= SOURCES; i++)
        if (wr && i_address == 24'(4 * i)) prio[i] <= i_wdata[PRIO_BITS-1:0];
      if (wr && i_address == 24'h002000) en <= {i_wdata[SOURCES:1], 1'b0};
      if (wr && i_address == 24'h200000) thr <= i_wdata[PRIO_BITS-1:0];
      o_ready     <= i_request;
      o_rdata     <= (i_request && !i_rw) ? rd : '0;
      o_interrupt <= i_interrupt_enable && |elig;
    end
  // Gateway: claim beats capture; completing an in-flight id returns it to idle.
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      pend <= '0;
      infl <= '0;
    end else begin
      for (int i = 1; i <= SOURCES; i++)
        if (rd_claim && win == 5'(i)) begin
          pend[i] <= 1'b0;
          infl[i] <= 1'b1;
        end else if (wr_cmp && i_wdata[4:0] == 5'(i) && infl[i]) begin
          infl[i] <= 1'b0;
          pend[i] <= repend[i];
        end else if (!pend[i] && !infl[i] && trig[i]) pend[i] <= 1'b1;
    end
endmodule

// File: tb/tb_plic_prio.sv
// tb_plic_prio: directed checks of plic_prio (SOURCES=8, PRIO_BITS=3).
module tb_plic_prio;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_interrupt = '0;
  logic        i_interrupt_enable = 1'b1;
  logic        o_interrupt;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [23:0] i_address = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_ready;
  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        rdy;

  plic_prio dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_interrupt(i_interrupt),
    .i_interrupt_enable(i_interrupt_enable), .o_interrupt(o_interrupt),
    .i_request(i_request), .i_rw(i_rw), .i_address(i_address), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_ready(o_ready)
  );

  always #5 i_clock = ~i_clock;

  task automatic bus(input logic rw, input logic [23:0] a, input logic [31:0] d);
    @(negedge i_clock);
    i_request = 1'b1; i_rw = rw; i_address = a; i_wdata = d;
    @(negedge i_clock);
    rd = o_rdata; rdy = o_ready;
    i_request = 1'b0; i_rw = 1'b0;
  endtask

  task automatic test_reset;
    logic [23:0] addrs [6] = '{24'h001000, 24'h002000, 24'h200000, 24'h200004, 24'h001080, 24'h000000};
    checks++; if (o_interrupt !== 1'b0 || o_ready !== 1'b0 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got int=%b rdy=%b rdata=%h exp 0 0 0", o_interrupt, o_ready, o_rdata); end
    @(negedge i_clock); i_reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus(1'b0, 24'(4 * i), 0);
      checks++; if (rd !== 32'h0 || rdy !== 1'b1) begin
        errors++; $display("FAIL reset_prio%0d got rd=%h rdy=%b exp 0 1", i, rd, rdy); end
    end
    foreach (addrs[k]) begin
      bus(1'b0, addrs[k], 0);
      checks++; if (rd !== 32'h0 || rdy !== 1'b1) begin
        errors++; $display("FAIL reset_reg_%h got rd=%h rdy=%b exp 0 1", addrs[k], rd, rdy); end
    end
    @(negedge i_clock);
    checks++; if (o_ready !== 1'b0 || o_rdata !== 32'h0 || o_interrupt !== 1'b0) begin
      errors++; $display("FAIL idle_after_access got rdy=%b rdata=%h int=%b exp 0 0 0", o_ready, o_rdata, o_interrupt); end
  endtask

  task automatic test_basic;
    bus(1'b1, 24'h00000C, 2);
    bus(1'b1, 24'h002000, 32'h08);
    bus(1'b1, 24'h200000, 1);
    bus(1'b0, 24'h002000, 0);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL enable_rb got %h exp 08", rd); end
    bus(1'b0, 24'h00000C, 0);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL prio3_rb got %h exp 2", rd); end
    i_interrupt = 8'h04;
    repeat (2) @(negedge i_clock);
    checks++; if (o_interrupt !== 1'b1) begin errors++; $display("FAIL basic_int got %b exp 1", o_interrupt); end
    bus(1'b0, 24'h001000, 0);
    checks++; if (rd !== 32'h08) begin errors++; $display("FAIL basic_pending got %h exp 08", rd); end
    bus(1'b0, 24'h200004, 0);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL basic_claim got %h exp 3", rd); end
    bus(1'b0, 24'h001000, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_pending_after got %h exp 0", rd); end
    checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL basic_int_after got %b exp 0", o_interrupt); end
    i_interrupt = 8'h00;
    bus(1'b1, 24'h200004, 3);
  endtask

  task automatic test_priority;
    logic [31:0] exp_ids [4] = '{32'd6, 32'd2, 32'd5, 32'd0};
    bus(1'b1, 24'h000008, 5);
    bus(1'b1, 24'h000014, 5);
    bus(1'b1, 24'h000018, 7);
    bus(1'b1, 24'h002000, 32'hFFFF_FFFF);
    bus(1'b0, 24'h002000, 0);
    checks++; if (rd !== 32'h1FE) begin errors++; $display("FAIL enable_mask got %h exp 1fe", rd); end
    i_interrupt = 8'h32;
    repeat (3) @(negedge i_clock);
    foreach (exp_ids[k]) begin
      bus(1'b0, 24'h200004, 0);
      checks++; if (rd !== exp_ids[k]) begin errors++; $display("FAIL prio_claim%0d got %0d exp %0d", k, rd, exp_ids[k]); end
    end
    checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL prio_int_after got %b exp 0", o_interrupt); end
    i_interrupt = 8'h00;
    bus(1'b1, 24'h200004, 6);
    bus(1'b1, 24'h200004, 2);
    bus(1'b1, 24'h200004, 5);
  endtask

  task automatic test_threshold;
    bus(1'b1, 24'h200000, 5);
    bus(1'b1, 24'h000004, 5);
    i_interrupt = 8'h01;
    repeat (3) @(negedge i_clock);
    checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL thr_equal_int got %b exp 0", o_interrupt); end
    bus(1'b0, 24'h001000, 0);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL thr_pending got %h exp 02", rd); end
    bus(1'b1, 24'h200000, 4);
    checks++; if (o_interrupt !== 1'b0) begin errors++; $display("FAIL thr_int_ready_cycle got %b exp 0", o_interrupt); end
    @(negedge i_clock);
    checks++; if (o_interrupt !== 1'b1) begin errors++; $display("FAIL thr_int_next got %b exp 1", o_interrupt); end
    bus(1'b0, 24'h200004, 0);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL thr_claim got %0d exp 1", rd); end
    i_interrupt = 8'h00;
    bus(1'b1, 24'h200004, 1);
  endtask

  task automatic test_complete;
    bus(1'b1, 24'h200000, 1);
    bus(1'b1, 24'h000010, 3);
    i_interrupt = 8'h08;
    repeat (2) @(negedge i_clock);
    bus(1'b0, 24'h200004, 0);
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL cmp_claim got %0d exp 4", rd); end
    repeat (3) @(negedge i_clock);
    bus(1'b0, 24'h001000, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cmp_no_repend got %h exp 0", rd); end
    bus(1'b1, 24'h200004, 7);
    bus(1'b0, 24'h001000, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cmp_wrong_id_pending got %h exp 0", rd); end
    bus(1'b0, 24'h200004, 0);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL cmp_empty_claim got %0d exp 0", rd); end
    bus(1'b1, 24'h200004, 4);
    bus(1'b0, 24'h001000, 0);
    checks++; if (rd !== 32'h10) begin errors++; $display("FAIL cmp_repend got %h exp 10", rd); end
    checks++; if (o_interrupt !== 1'b1) begin errors++; $display("FAIL cmp_int got %b exp 1", o_interrupt); end
    bus(1'b0, 24'h200004, 0);
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL cmp_reclaim got %0d exp 4", rd); end
    i_interrupt = 8'h00;
    bus(1'b1, 24'h200004, 4);
  endtask

  task automatic test_edge;
`ifdef PLIC_EDGE_EN
    bus(1'b1, 24'h001080, 32'h02);
    bus(1'b0, 24'h001080, 0);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL edge_rb got %h exp 02", rd); end
    @(negedge i_clock); i_interrupt = 8'h01;
    @(negedge i_clock); i_interrupt = 8'h00;
    repeat (4) @(negedge i_clock);
    bus(1'b0, 24'h200004, 0);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL edge_claim got %0d exp 1", rd); end
    @(negedge i_clock); i_interrupt = 8'h01;
    @(negedge i_clock); i_interrupt = 8'h00;
    repeat (4) @(negedge i_clock);
    bus(1'b0, 24'h001000, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_inflight_pending got %h exp 0", rd); end
    bus(1'b1, 24'h200004, 1);
    bus(1'b0, 24'h001000, 0);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL edge_latched got %h exp 02", rd); end
    bus(1'b0, 24'h200004, 0);
    bus(1'b1, 24'h200004, 1);
`else
    bus(1'b1, 24'h001080, 32'hFF);
    bus(1'b0, 24'h001080, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_reg_absent got %h exp 0", rd); end
`endif
  endtask

  task automatic test_reset_midaccess;
    @(negedge i_clock);
    i_request = 1'b1; i_rw = 1'b0; i_address = 24'h002000;
    #2 i_reset = 1'b1;
    @(negedge i_clock);
    checks++; if (o_ready !== 1'b0 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_abort got rdy=%b rdata=%h exp 0 0", o_ready, o_rdata); end
    i_request = 1'b0;
    i_reset = 1'b0;
    bus(1'b0, 24'h002000, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_enable_cleared got %h exp 0", rd); end
    bus(1'b0, 24'h000018, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_prio6_cleared got %h exp 0", rd); end
  endtask

  initial begin
    repeat (2) @(negedge i_clock);
    test_reset;
    test_basic;
    test_priority;
    test_threshold;
    test_complete;
    test_edge;
    test_reset_midaccess;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
